// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer (SS.t) with push-button preset/start control,
// active-low 7-segment outputs and an alarm when the count reaches 00.0.
module countdown_timer #(
  parameter int FREQ_MHZ = 50,
  parameter int TICK_MS  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_set,
  input  logic       key_start,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       alarm,
  output logic       running
);

  localparam int DIV = FREQ_MHZ * 1000 * TICK_MS;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    t, u, d, t_n, u_n, d_n;
  logic [3:0]    pu, pd, pu_n, pd_n;
  logic [3:0]    dec_t, dec_u, dec_d;
  logic          tick, count_is_one, preset_zero;

  logic [1:0] set_sync, start_sync;
  logic       set_prev, start_prev;
  logic       set_p, start_p;

  // Two-flop synchronizer, then a registered falling-edge detector per key.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_sync   <= '1;
      start_sync <= '1;
      set_prev   <= 1'b1;
      start_prev <= 1'b1;
      set_p      <= 1'b0;
      start_p    <= 1'b0;
    end else begin
      set_sync   <= {set_sync[0], key_set};
      start_sync <= {start_sync[0], key_start};
      set_prev   <= set_sync[1];
      start_prev <= start_sync[1];
      set_p      <= set_prev & ~set_sync[1];
      start_p    <= start_prev & ~start_sync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      t     <= '0;
      u     <= '0;
      d     <= '0;
      pu    <= '0;
      pd    <= '0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      t     <= t_n;
      u     <= u_n;
      d     <= d_n;
      pu    <= pu_n;
      pd    <= pd_n;
    end
  end

  always_comb begin
    tick         = (state == RUN) && (presc == DIV_M1);
    count_is_one = (d == 4'd0) && (u == 4'd0) && (t == 4'd1);
    preset_zero  = (pd == 4'd0) && (pu == 4'd0);

    dec_t = t - 4'd1;
    dec_u = u;
    dec_d = d;
    if (t == 4'd0) begin
      dec_t = 4'd9;
      dec_u = u - 4'd1;
      if (u == 4'd0) begin
        dec_u = 4'd9;
        dec_d = d - 4'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    t_n     = t;
    u_n     = u;
    d_n     = d;
    pu_n    = pu;
    pd_n    = pd;

    case (state)
      IDLE: begin
        // Display tracks the preset with one cycle of lag after a set press.
        t_n = '0;
        u_n = pu;
        d_n = pd;
        if (start_p) begin
          if (!preset_zero) begin
            state_n = RUN;
            presc_n = '0;
          end
        end else if (set_p) begin
          if (pu == 4'd9) begin
            pu_n = '0;
            pd_n = (pd == 4'd9) ? 4'd0 : pd + 4'd1;
          end else begin
            pu_n = pu + 4'd1;
          end
        end
      end

      RUN: begin
        presc_n = tick ? '0 : presc + PW'(1);
        if (tick) begin
          t_n = dec_t;
          u_n = dec_u;
          d_n = dec_d;
        end
        if (tick && count_is_one) state_n = ALARM;
        else if (start_p)         state_n = PAUSE;
      end

      PAUSE: begin
        if (start_p) begin
          state_n = RUN;
        end else if (set_p) begin
          state_n = IDLE;
          presc_n = '0;
          t_n     = '0;
          u_n     = pu;
          d_n     = pd;
        end
      end

      ALARM: begin
        t_n = '0;
        u_n = '0;
        d_n = '0;
        if (set_p || start_p) begin
          state_n = IDLE;
          u_n     = pu;
          d_n     = pd;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      HEX0 <= 7'b1000000;
      HEX1 <= 7'b1000000;
      HEX2 <= 7'b1000000;
    end else begin
      HEX0 <= seg(t);
      HEX1 <= seg(u);
      HEX2 <= seg(d);
    end
  end

  assign alarm   = (state == ALARM);
  assign running = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at FREQ_MHZ=1, TICK_MS=1 (1000 clk per tick);
// event edges are counted relative to the clk edge where a press takes effect.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_set = 1'b1;
  logic       key_start = 1'b1;
  logic [6:0] HEX0, HEX1, HEX2;
  logic       alarm, running;

  int total = 0;
  int bad   = 0;
  int pos   = 0;

  logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  countdown_timer #(.FREQ_MHZ(1), .TICK_MS(1)) dut (
    .clk(clk), .rst(rst), .key_set(key_set), .key_start(key_start),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .alarm(alarm), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hex(input string tag, input int dd, input int uu, input int tt);
    chk({tag, ".HEX2"}, {25'd0, HEX2}, {25'd0, SEG[dd]});
    chk({tag, ".HEX1"}, {25'd0, HEX1}, {25'd0, SEG[uu]});
    chk({tag, ".HEX0"}, {25'd0, HEX0}, {25'd0, SEG[tt]});
  endtask

  // Returns 1ns after the clk edge on which the FSM acts on the press (pos=0).
  task automatic press(input bit s, input bit st);
    @(negedge clk);
    if (s)  key_set = 1'b0;
    if (st) key_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    key_set = 1'b1;
    key_start = 1'b1;
    pos = 0;
  endtask

  task automatic to_edge(input int target);
    repeat (target - pos) @(posedge clk);
    pos = target;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_set = 1'b1;
    key_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_presses(input int n);
    for (int i = 0; i < n; i++) begin
      press(1'b1, 1'b0);
      to_edge(3);
    end
  endtask

  initial begin
    // 1: reset values, preset entry and wrap
    do_reset();
    chk_hex("reset", 0, 0, 0);
    chk("reset.alarm", {31'd0, alarm}, 32'd0);
    chk("reset.running", {31'd0, running}, 32'd0);
    set_presses(12);
    chk_hex("preset12", 1, 2, 0);

    do_reset();
    set_presses(9);
    chk_hex("preset09", 0, 9, 0);
    set_presses(1);
    chk_hex("preset10", 1, 0, 0);
    set_presses(89);
    chk_hex("preset99", 9, 9, 0);
    set_presses(1);
    chk_hex("preset_wrap", 0, 0, 0);

    // 2: run from 02.0 down to alarm
    do_reset();
    set_presses(2);
    press(1'b0, 1'b1);
    chk("run2.running", {31'd0, running}, 32'd1);
    to_edge(19999);
    chk("run2.pre_alarm", {31'd0, alarm}, 32'd0);
    chk_hex("run2.one_tenth", 0, 0, 1);
    to_edge(20000);
    chk("run2.alarm", {31'd0, alarm}, 32'd1);
    chk("run2.run_off", {31'd0, running}, 32'd0);
    to_edge(20001);
    chk_hex("run2.zero", 0, 0, 0);

    // 3: pause at 00.7, hold, resume
    do_reset();
    set_presses(1);
    press(1'b0, 1'b1);
    to_edge(3496);
    press(1'b0, 1'b1);
    chk("pause.running", {31'd0, running}, 32'd0);
    to_edge(2);
    chk_hex("pause.count", 0, 0, 7);
    to_edge(5000);
    chk_hex("pause.frozen", 0, 0, 7);
    chk("pause.alarm", {31'd0, alarm}, 32'd0);
    press(1'b0, 1'b1);
    chk("resume.running", {31'd0, running}, 32'd1);
    to_edge(6499);
    chk("resume.pre_alarm", {31'd0, alarm}, 32'd0);
    to_edge(6500);
    chk("resume.alarm", {31'd0, alarm}, 32'd1);

    // 4: start with preset 00; pause then set returns to IDLE
    do_reset();
    press(1'b0, 1'b1);
    chk("zero_start.running", {31'd0, running}, 32'd0);
    to_edge(2);
    chk_hex("zero_start", 0, 0, 0);
    set_presses(3);
    press(1'b0, 1'b1);
    to_edge(1500);
    press(1'b0, 1'b1);
    chk("p2i.paused", {31'd0, running}, 32'd0);
    to_edge(3);
    press(1'b1, 1'b0);
    to_edge(2);
    chk_hex("p2i.preset", 0, 3, 0);
    chk("p2i.running", {31'd0, running}, 32'd0);
    chk("p2i.alarm", {31'd0, alarm}, 32'd0);

    // 5: acknowledge alarm, then simultaneous set+start in IDLE
    do_reset();
    set_presses(1);
    press(1'b0, 1'b1);
    to_edge(10000);
    chk("ack.alarm_on", {31'd0, alarm}, 32'd1);
    to_edge(10050);
    press(1'b0, 1'b1);
    chk("ack.alarm_off", {31'd0, alarm}, 32'd0);
    to_edge(1);
    chk_hex("ack.preset", 0, 1, 0);
    to_edge(3);
    press(1'b1, 1'b1);
    chk("both.running", {31'd0, running}, 32'd1);
    to_edge(1);
    chk_hex("both.load", 0, 1, 0);
    to_edge(1001);
    chk_hex("both.tick1", 0, 0, 9);

    // 6: reset mid-run at 05.3, then a held key
    do_reset();
    set_presses(6);
    press(1'b0, 1'b1);
    to_edge(7200);
    chk_hex("midrun", 0, 5, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_hex("midrun_rst", 0, 0, 0);
    chk("midrun_rst.alarm", {31'd0, alarm}, 32'd0);
    chk("midrun_rst.running", {31'd0, running}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    press(1'b0, 1'b1);
    chk("preset_lost.running", {31'd0, running}, 32'd0);
    to_edge(3);
    @(negedge clk);
    key_set = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    key_set = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_hex("held_key", 0, 1, 0);
    press(1'b0, 1'b1);
    chk("held_key.running", {31'd0, running}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Three-digit BCD countdown timer (SS.t, 00.0–99.9 s) for the FPGA board. It is the down-counting counterpart of the stopwatch. The user sets a preset in whole seconds with one push-button and starts or pauses with another. The count is shown on three active-low 7-segment digits, and alarm is raised when the count reaches 00.0.

Parameters:
FREQ_MHZ, 50, input clock frequency in MHz
TICK_MS, 100, countdown resolution in ms (one tenth-digit step)
DIV (localparam), FREQ_MHZ*1000*TICK_MS, clk cycles per tick

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
key_set  input  1  raw push-button, active-low, asynchronous; increments preset seconds
key_start  input  1  raw push-button, active-low, asynchronous; start/pause/acknowledge
HEX0  output  7  tenths digit, active-low segments {g,f,e,d,c,b,a}
HEX1  output  7  seconds units digit, same encoding
HEX2  output  7  seconds tens digit, same encoding
alarm  output  1  high while in ALARM
running  output  1  high while in RUN

Behaviour:
- Reset: rst is synchronous, active-high, on clk. All state clears on the clk edge where rst=1: state=IDLE, preset=00, count=00.0, prescaler=0, alarm=0, running=0, HEX0..2=7'b1000000 ("0"). Synchronizer flops reset to 1 (button released).
- Button input: each key passes through a 2-flop synchronizer. A press is a falling edge, detected as prev=1 and cur=0. It yields a 1-cycle pulse (set_p, start_p) registered 3 clk after the pin falls. Holding a key gives exactly one pulse.
- Digits: tenths t, units u and tens d are each 4-bit BCD, range 0–9. preset is two BCD digits {pd, pu}.
- Prescaler: counts 0..DIV-1, only in RUN. tick=1 for one cycle when prescaler==DIV-1, and the prescaler wraps to 0 on that cycle.
- BCD decrement on tick: t-1. If t==0 then t=9 and borrow into u. If u==0 then u=9 and borrow into d. Underflow below 00.0 cannot occur (see RUN).
- FSM IDLE:
  - count shows {pd, pu, 0}.
  - set_p: preset += 1 s in BCD (09→10, 99→00). count reloads to the new preset on the next cycle.
  - start_p with preset≠00: load count={pd, pu, 0}, clear prescaler, go to RUN.
  - start_p with preset==00: ignored, stay in IDLE.
- FSM RUN:
  - tick decrements count.
  - If a tick takes count from 00.1 to 00.0, go to ALARM on the same edge.
  - start_p: go to PAUSE; prescaler frozen, value kept.
  - set_p: ignored.
- FSM PAUSE:
  - count and prescaler frozen.
  - start_p: go to RUN, resuming from the frozen prescaler value.
  - set_p: reload count from preset, prescaler=0, go to IDLE.
- FSM ALARM:
  - count held at 00.0, alarm=1.
  - Either set_p or start_p: go to IDLE, count reloaded from preset, alarm=0 the next cycle. preset is unchanged by the acknowledging set_p.
- Simultaneous set_p and start_p in one cycle: start_p takes priority, set_p is dropped. Exception: in ALARM both simply acknowledge.
- tick and start_p in the same RUN cycle: apply the decrement, then go to PAUSE. If that decrement reaches 00.0, go to ALARM instead.
- Outputs: HEX0..2 are registered from the BCD digits via the segment decoder, 1 clk after the count changes. Patterns are 0=1000000, 1=1111001, …, 9=0010000; codes A–F are never produced. alarm and running are decoded directly from the state register.
- Reset asserted mid-RUN or mid-ALARM: the next edge forces all reset values. Preset is lost.

Test Plan:
(Bench uses FREQ_MHZ=1, TICK_MS=1, so DIV=1000.)
1. Reset, then 12 set presses → HEX2/HEX1/HEX0 show 1/2/0. 100 presses from 00 → wraps to 00.
2. Preset 02, start → running=1. After 20 ticks (20000 clk) → alarm=1 and count=00.0. One tick earlier, count=00.1 and alarm=0.
3. Preset 01, start, pause after 3500 clk (count 00.7), wait 5000 clk → count stays 00.7. Resume → alarm exactly 6500 clk after resume.
4. Start with preset 00 → state stays IDLE, running=0. Pause then set → IDLE showing preset.
5. In ALARM, press start → alarm drops the next cycle, display shows the preset. Set and start pressed in the same cycle in IDLE → RUN, preset unchanged.
6. Assert rst during RUN at count 05.3 → next cycle all HEX=1000000, alarm=0, running=0. A held key produces only one press.
